// File: rtl/i2s_tx_pkg.sv
// Shared types and defaults for the I2S transmit slave.
package i2s_tx_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLOT  = 32;

  typedef logic signed [DEF_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } tx_state_t;
endpackage

// File: rtl/i2s_tx_slave_fifo.sv
// audio_fifo: synchronous sample FIFO with wrap-bit pointers; guards its own push/pop.
module audio_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/synchronizer.sv
// Multi-bit 2-FF synchronizer for slow, independently sampled inputs.
module synchronizer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/i2s_tx_slave.sv
// Mono I2S transmitter slaved to codec BCLK/LRCLK, fed from a sample FIFO.
// Define I2S_TX_MUTE_ON_UNDERFLOW_EN to output silence instead of repeating on underflow.
module i2s_tx_slave
  import i2s_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 8,
  parameter int SLOT  = DEF_SLOT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en_a,
  input  logic signed [WIDTH-1:0] audio,
  input  logic                    bclk,
  input  logic                    lrclk,
  input  logic                    clear_flags,
  output logic                    sdata,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    underflow,
  output logic                    overflow
);
  localparam int CW = $clog2(WIDTH);

  logic             bclk_s, lr_s, bclk_d;
  logic             bclk_rise, bclk_fall;
  logic             lr_q, lr_last;
  logic             slot_start, left_start;
  logic             full, empty;
  logic [WIDTH-1:0] head, cur, shreg, load_smp;
  logic [CW-1:0]    bit_cnt;
  tx_state_t        state;

  synchronizer #(.W(2)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({lrclk, bclk}),
    .q       ({lr_s, bclk_s})
  );

  assign bclk_rise = bclk_s && !bclk_d;
  assign bclk_fall = !bclk_s && bclk_d;

  // LRCLK is captured on the rise, compared on the fall: one-BCLK I2S delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_d  <= 1'b0;
      lr_q    <= 1'b0;
      lr_last <= 1'b0;
    end else begin
      bclk_d <= bclk_s;
      if (bclk_rise) lr_q    <= lr_s;
      if (bclk_fall) lr_last <= lr_q;
    end
  end

  assign slot_start = bclk_fall && (lr_q != lr_last);
  assign left_start = slot_start && !lr_q;

  audio_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (en_a),
    .pop     (left_start),
    .wdata   (audio),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    load_smp = cur;
    if (left_start) begin
      if (!empty) load_smp = head;
`ifdef I2S_TX_MUTE_ON_UNDERFLOW_EN
      else        load_smp = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sdata   <= 1'b0;
      cur     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (slot_start) begin
      state   <= SHIFT;
      cur     <= load_smp;
      sdata   <= load_smp[WIDTH-1];
      shreg   <= {load_smp[WIDTH-2:0], 1'b0};
      bit_cnt <= '0;
    end else if (bclk_fall) begin
      case (state)
        SHIFT: begin
          if (bit_cnt == CW'(WIDTH-1)) begin
            sdata <= 1'b0;
            state <= (SLOT > WIDTH) ? PAD : SHIFT;
          end else begin
            sdata   <= shreg[WIDTH-1];
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: sdata <= 1'b0;
      endcase
    end
  end

  // Set events win over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (left_start && empty)             underflow <= 1'b1;
      else if (clear_flags)                underflow <= 1'b0;
      if (en_a && full && !left_start)     overflow  <= 1'b1;
      else if (clear_flags)                overflow  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2s_tx_slave.sv
// Scoreboarded bench: codec-side BCLK/LRCLK generator, queue-based reference model, serial monitor.
`timescale 1ns/1ps
module tb_i2s_tx_slave;
  import i2s_tx_pkg::*;

  localparam int  DEPTH = 8;
  localparam int  WIDTH = 16;
  localparam int  SLOT  = 32;
  localparam int  HALF  = 10;     // clk cycles per BCLK half period (~2.048 MHz)
  localparam real CLK_P = 24.4;

  logic       clk = 0, reset_n = 0, en_a = 0, bclk = 1, lrclk = 1, clear_flags = 0;
  sample_t    audio = '0;
  logic       sdata, underflow, overflow;
  logic [3:0] level;

  int checks = 0, errors = 0;

  logic [15:0] fifo_m[$];
  logic [15:0] exp_q[$];
  logic [15:0] cur_m = '0;
  bit uf_m = 0, of_m = 0;
  bit mon_en = 1, quiet_watch = 0, quiet_bad = 0;

  i2s_tx_slave #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SLOT(SLOT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en_a        (en_a),
    .audio       (audio),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .clear_flags (clear_flags),
    .sdata       (sdata),
    .level       (level),
    .underflow   (underflow),
    .overflow    (overflow)
  );

  always #(CLK_P/2) clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain queue semantics on the pre-cycle state.
  task automatic model_push(input logic [15:0] v);
    if (fifo_m.size() == DEPTH) of_m = 1;
    else fifo_m.push_back(v);
  endtask

  task automatic model_pop();
    if (fifo_m.size() != 0) cur_m = fifo_m.pop_front();
    else begin
      uf_m = 1;
`ifdef I2S_TX_MUTE_ON_UNDERFLOW_EN
      cur_m = '0;
`endif
    end
  endtask

  task automatic push_sample(input logic [15:0] v);
    @(negedge clk); en_a = 1; audio = v;
    @(negedge clk); en_a = 0;
    model_push(v);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_level"}, 32'(level), 32'(fifo_m.size()));
    chk({tag, "_underflow"}, 32'(underflow), 32'(uf_m));
    chk({tag, "_overflow"}, 32'(overflow), 32'(of_m));
  endtask

  task automatic do_clear();
    @(negedge clk); clear_flags = 1;
    @(negedge clk); clear_flags = 0;
    uf_m = 0; of_m = 0;
    check_state("clear");
  endtask

  // One BCLK period; optional push lands in the cycle the slot start is acted on.
  task automatic do_bit(input logic lr_v, input bit p, input logic [15:0] v, input bit rst_here);
    @(negedge clk); bclk = 0; lrclk = lr_v;
    for (int i = 1; i < HALF; i++) begin
      @(negedge clk);
      en_a = p && (i == 2);
      if (p && i == 2) audio = v;
      if (rst_here && i == 5) begin
        chk("t6_pre_reset_sdata", 32'(sdata), 32'd1);
        reset_n = 0;
        #1;
        chk("t6_reset_sdata", 32'(sdata), 32'd0);
        chk("t6_reset_level", 32'(level), 32'd0);
      end
      if (rst_here && i == 7) reset_n = 1;
    end
    @(negedge clk); bclk = 1;
    repeat (HALF-1) @(negedge clk);
  endtask

  task automatic run_frames(input int n, input bit cpush, input logic [15:0] cval);
    for (int f = 0; f < n; f++)
      for (int ch = 0; ch < 2; ch++)
        for (int b = 0; b < SLOT; b++) begin
          bit p;
          p = cpush && f == 0 && ch == 0 && b == 1;
          if (b == 1) begin
            if (ch == 0) model_pop();
            if (p) model_push(cval);
            exp_q.push_back(cur_m);
          end
          do_bit(ch[0], p, cval, 1'b0);
        end
  endtask

  // Monitor: codec view at BCLK rise, plus a sample 4 clk after each fall.
  initial begin
    logic prev_lr, early, late;
    logic [15:0] word_l, word_e, e;
    int pos;
    bit padbad;
    prev_lr = 1; pos = 0; word_l = '0; word_e = '0; padbad = 0;
    forever begin
      @(negedge bclk);
      #(4*CLK_P - 1.0);
      early = sdata;
      @(posedge bclk);
      late = sdata;
      if (lrclk !== prev_lr) pos = 0; else pos++;
      prev_lr = lrclk;
      if (mon_en) begin
        if (pos >= 1 && pos <= WIDTH) begin
          word_l = {word_l[14:0], late};
          word_e = {word_e[14:0], early};
        end else if (late !== 1'b0 || early !== 1'b0) padbad = 1;
        if (pos == SLOT-1) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL slot_word: got 0x%0h, want no slot", word_l);
          end else begin
            e = exp_q.pop_front();
            chk("slot_word", 32'(word_l), 32'(e));
            chk("slot_word_4clk", 32'(word_e), 32'(e));
          end
          chk("slot_pad", 32'(padbad), 32'd0);
          padbad = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge bclk);
    if (quiet_watch && sdata !== 1'b0) quiet_bad = 1;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_sdata", 32'(sdata), 32'd0);
    check_state("reset");
    reset_n = 1;
    repeat (5) @(negedge clk);

    // Basic frame
    push_sample(16'h8001);
    run_frames(1, 0, '0);
    check_state("t1");

    // Underflow: repeat (or mute) after the only sample
    push_sample(16'h1234);
    run_frames(3, 0, '0);
    check_state("t4");
    do_clear();

    // Overflow with BCLK stopped
    repeat (9) push_sample(16'($urandom));
    check_state("t3");
    do_clear();

    // Full FIFO, push coincident with left pop
    run_frames(1, 1, 16'($urandom));
    check_state("t5_full");
    run_frames(8, 0, '0);
    check_state("drain");

    // Empty FIFO, push coincident with left pop
    run_frames(1, 1, 16'($urandom));
    check_state("t5_empty");
    run_frames(1, 0, '0);
    check_state("t5_after");
    do_clear();

    for (int it = 0; it < 5; it++) begin
      int k, nf;
      bit cp;
      k  = $urandom_range(0, 5);
      nf = $urandom_range(1, 2);
      cp = 1'($urandom_range(0, 1));
      repeat (k) push_sample(16'($urandom));
      run_frames(nf, cp, 16'($urandom));
      check_state("rand");
      do_clear();
    end

    while (fifo_m.size() != 0) run_frames(1, 0, '0);
    check_state("flush");
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid left slot, then silence until the next LRCLK edge
    mon_en = 0;
    push_sample(16'hFFFF);
    push_sample(16'h5A5A);
    for (int b = 0; b < SLOT; b++) begin
      do_bit(1'b0, 0, '0, b == 8);
      if (b == 8) begin
        fifo_m.delete(); cur_m = '0; uf_m = 0; of_m = 0;
        quiet_watch = 1;
      end
    end
    for (int b = 0; b < SLOT; b++) do_bit(1'b1, 0, '0, 1'b0);
    chk("t6_uf_before_left", 32'(underflow), 32'd0);
    for (int b = 0; b < SLOT; b++) begin
      if (b == 1) model_pop();
      do_bit(1'b0, 0, '0, 1'b0);
      if (b == 1) chk("t6_uf_first_left", 32'(underflow), 32'(uf_m));
    end
    for (int b = 0; b < SLOT; b++) do_bit(1'b1, 0, '0, 1'b0);
    quiet_watch = 0;
    chk("t6_quiet", 32'(quiet_bad), 32'd0);
    check_state("t6_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
